// File: rtl/gray_to_rgb565_palette_if.sv
// Valid/ready pixel stream with frame/line sideband, shared by the input
// (8-bit gray) and output (16-bit RGB565) sides of the palette mapper.
interface gray_to_rgb565_palette_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         sof;
  logic         eol;
  logic         ready;

  modport master (output data, output valid, output sof, output eol, input ready);
  modport slave  (input data, input valid, input sof, input eol, output ready);
endinterface

// File: rtl/gray_to_rgb565_palette.sv
// Streaming 8-bit intensity to RGB565 false-colour mapper: gray, hot, jet or
// inverted gray, 3-stage pipeline with a single global stall enable.
module gray_to_rgb565_palette #(
  parameter logic [1:0] P_RESET_MODE = 2'd2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  gray_to_rgb565_palette_if.slave       s_pix,
  gray_to_rgb565_palette_if.master      m_pix,
  input  logic [1:0]                    i_mode,
  output logic [1:0]                    o_mode
);

  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_HOT  = 2'd1,
    MODE_JET  = 2'd2,
    MODE_INV  = 2'd3
  } palette_e;

  logic en;
  logic accept;
  assign en          = m_pix.ready | ~m_pix.valid;
  assign s_pix.ready = en;
  assign accept      = s_pix.valid & en;

  // A sof pixel carries its own new mode; everything else uses the latched one.
  logic [1:0] pix_mode;
  assign pix_mode = s_pix.sof ? i_mode : o_mode;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mode <= P_RESET_MODE;
    end else if (accept && s_pix.sof) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      o_mode <= i_mode;
    end
  end

  // S1: registered input pixel plus the palette it will be mapped with
  logic       s1_valid, s1_sof, s1_eol;
  logic [7:0] s1_gray;
  palette_e   s1_mode;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: data registers are reset too, so o_rgb reads zero straight out of reset.
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_gray  <= 8'h00;
      s1_mode  <= MODE_GRAY;
    end else if (en) begin
      s1_valid <= s_pix.valid;
      s1_sof   <= s_pix.sof;
      s1_eol   <= s_pix.eol;
      s1_gray  <= s_pix.data;
      s1_mode  <= palette_e'(pix_mode);
    end
  end

  logic [9:0] hot_t;
  logic [7:0] jet_f;
  logic [7:0] r8, g8, b8;

  assign hot_t = {2'b00, s1_gray} + {1'b0, s1_gray, 1'b0};
  assign jet_f = {s1_gray[5:0], 2'b00};

  always_comb begin
    // NOTE: defaults first so every path assigns r8/g8/b8 and no latch is inferred.
    r8 = 8'h00;
    g8 = 8'h00;
    b8 = 8'h00;
    unique case (s1_mode)
      MODE_GRAY: begin
        r8 = s1_gray;
        g8 = s1_gray;
        b8 = s1_gray;
      end
      MODE_INV: begin
        r8 = ~s1_gray;
        g8 = ~s1_gray;
        b8 = ~s1_gray;
      end
      MODE_HOT: begin
        r8 = (hot_t > 10'd255) ? 8'hFF : hot_t[7:0];
        if (hot_t >= 10'd510)     g8 = 8'hFF;
        else if (hot_t > 10'd255) g8 = 8'(hot_t - 10'd255);
        if (hot_t > 10'd510)      b8 = 8'(hot_t - 10'd510);
      end
      MODE_JET: begin
        unique case (s1_gray[7:6])
          2'd0: begin g8 = jet_f;         b8 = 8'hFF;          end
          2'd1: begin g8 = 8'hFF;         b8 = ~jet_f;         end
          2'd2: begin r8 = jet_f;         g8 = 8'hFF;          end
          2'd3: begin r8 = 8'hFF;         g8 = ~jet_f;         end
        endcase
      end
    endcase
  end

  // S2: full-precision colour components
  logic       s2_valid, s2_sof, s2_eol;
  logic [7:0] s2_r, s2_g, s2_b;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_r     <= 8'h00;
      s2_g     <= 8'h00;
      s2_b     <= 8'h00;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
      s2_r     <= r8;
      s2_g     <= g8;
      s2_b     <= b8;
    end
  end

  // S3: truncating RGB565 pack straight into the output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_pix.valid <= 1'b0;
      m_pix.sof   <= 1'b0;
      m_pix.eol   <= 1'b0;
      m_pix.data  <= 16'h0000;
    end else if (en) begin
      m_pix.valid <= s2_valid;
      m_pix.sof   <= s2_sof;
      m_pix.eol   <= s2_eol;
      m_pix.data  <= {s2_r[7:3], s2_g[7:2], s2_b[7:3]};
    end
  end

endmodule

// File: tb/tb_gray_to_rgb565_palette.sv
// Directed bench for gray_to_rgb565_palette: table of single-pixel vectors,
// then a stalled stream and an asynchronous mid-stream reset.
module tb_gray_to_rgb565_palette;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [1:0] o_mode;

  gray_to_rgb565_palette_if #(.W(8))  in_if ();
  gray_to_rgb565_palette_if #(.W(16)) out_if ();

  gray_to_rgb565_palette #(.P_RESET_MODE(2'd2)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .s_pix  (in_if),
    .m_pix  (out_if),
    .i_mode (mode),
    .o_mode (o_mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        sof;
    logic        eol;
    logic [7:0]  gray;
    logic [15:0] rgb;
    logic [1:0]  exp_mode;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic send_one(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    in_if.valid = 1'b1;
    in_if.data  = v.gray;
    in_if.sof   = v.sof;
    in_if.eol   = v.eol;
    mode        = v.mode;
    #1;
    check($sformatf("v%0d ready", idx), {31'd0, in_if.ready}, 32'd1);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      in_if.valid = 1'b0;
      in_if.sof   = 1'b0;
      in_if.eol   = 1'b0;
      lat++;
      #1;
      if (out_if.valid) break;
    end
    check($sformatf("v%0d latency", idx), lat, 3);
    check($sformatf("v%0d rgb", idx), {16'd0, out_if.data}, {16'd0, v.rgb});
    check($sformatf("v%0d sof/eol", idx), {30'd0, out_if.sof, out_if.eol}, {30'd0, v.sof, v.eol});
    check($sformatf("v%0d o_mode", idx), {30'd0, o_mode}, {30'd0, v.exp_mode});
    @(negedge clk);
  endtask

  logic [15:0] exp_stream[4];
  logic [15:0] prev_rgb;
  logic        prev_stalled;
  int          pix_idx;
  int          got;
  logic [7:0]  stream_gray[4];

  initial begin
    // mode, sof, eol, gray, expected rgb, expected o_mode
    vecs[0]  = '{2'd0, 1'b0, 1'b0, 8'd0,   16'h001F, 2'd2};
    vecs[1]  = '{2'd0, 1'b0, 1'b0, 8'd200, 16'hFEE0, 2'd2};
    vecs[2]  = '{2'd0, 1'b0, 1'b1, 8'd128, 16'h07E0, 2'd2};
    vecs[3]  = '{2'd1, 1'b1, 1'b0, 8'd100, 16'hF960, 2'd1};
    vecs[4]  = '{2'd1, 1'b0, 1'b0, 8'd0,   16'h0000, 2'd1};
    vecs[5]  = '{2'd1, 1'b0, 1'b1, 8'd255, 16'hFFFF, 2'd1};
    vecs[6]  = '{2'd0, 1'b1, 1'b0, 8'h80,  16'h8410, 2'd0};
    vecs[7]  = '{2'd0, 1'b0, 1'b0, 8'hFF,  16'hFFFF, 2'd0};
    vecs[8]  = '{2'd0, 1'b0, 1'b0, 8'h00,  16'h0000, 2'd0};
    vecs[9]  = '{2'd3, 1'b0, 1'b0, 8'h40,  16'h4208, 2'd0};
    vecs[10] = '{2'd3, 1'b1, 1'b0, 8'h00,  16'hFFFF, 2'd3};
    vecs[11] = '{2'd3, 1'b0, 1'b1, 8'h10,  16'hEF7D, 2'd3};
    vecs[12] = '{2'd0, 1'b1, 1'b0, 8'h10,  16'h1082, 2'd0};

    exp_stream  = '{16'h1082, 16'h2104, 16'h3186, 16'h4208};
    stream_gray = '{8'h10, 8'h20, 8'h30, 8'h40};

    in_if.valid  = 1'b0;
    in_if.data   = 8'h00;
    in_if.sof    = 1'b0;
    in_if.eol    = 1'b0;
    out_if.ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("reset o_valid", {31'd0, out_if.valid}, 32'd0);
    check("reset o_rgb", {16'd0, out_if.data}, 32'd0);
    check("reset o_mode", {30'd0, o_mode}, 32'd2);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) send_one(vecs[i], i);

    // Stream of four pixels, downstream stalled for cycles 3..7
    pix_idx = 0;
    got = 0;
    prev_stalled = 1'b0;
    prev_rgb = 16'h0000;
    mode = 2'd0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_if.ready = !(cyc >= 3 && cyc <= 7);
      if (pix_idx < 4) begin
        in_if.valid = 1'b1;
        in_if.data  = stream_gray[pix_idx];
        in_if.sof   = (pix_idx == 0);
        in_if.eol   = (pix_idx == 3);
      end else begin
        in_if.valid = 1'b0;
        in_if.sof   = 1'b0;
        in_if.eol   = 1'b0;
      end
      #1;
      if (!out_if.ready && out_if.valid) begin
        check($sformatf("stall c%0d o_ready", cyc), {31'd0, in_if.ready}, 32'd0);
        if (prev_stalled)
          check($sformatf("stall c%0d rgb hold", cyc), {16'd0, out_if.data}, {16'd0, prev_rgb});
        prev_stalled = 1'b1;
      end else begin
        prev_stalled = 1'b0;
      end
      prev_rgb = out_if.data;
      if (out_if.valid && out_if.ready) begin
        if (got < 4) begin
          check($sformatf("stream px%0d rgb", got), {16'd0, out_if.data}, {16'd0, exp_stream[got]});
          check($sformatf("stream px%0d sof/eol", got), {30'd0, out_if.sof, out_if.eol},
                {30'd0, (got == 0), (got == 3)});
        end else begin
          check("stream extra pixel", got, 3);
        end
        got++;
      end
      if (in_if.valid && in_if.ready) pix_idx++;
    end
    check("stream pixel count", got, 4);
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;

    // Three pixels in flight, then asynchronous reset between clock edges
    mode = 2'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_if.valid = 1'b1;
      in_if.data  = 8'h20 + 8'(k);
      in_if.sof   = (k == 0);
      in_if.eol   = 1'b0;
    end
    @(negedge clk);
    in_if.valid = 1'b0;
    in_if.sof   = 1'b0;
    #1;
    check("pre-reset o_valid", {31'd0, out_if.valid}, 32'd1);
    check("pre-reset o_mode", {30'd0, o_mode}, 32'd3);
    #1;
    rst = 1'b1;
    #1;
    check("async reset o_valid", {31'd0, out_if.valid}, 32'd0);
    check("async reset o_rgb", {16'd0, out_if.data}, 32'd0);
    check("async reset o_mode", {30'd0, o_mode}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-reset c%0d o_valid", k), {31'd0, out_if.valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_to_rgb565_palette.md
Name: gray_to_rgb565_palette

Overview:
Streaming 8-bit grayscale/thermal intensity to RGB565 false-colour mapper for the display path of the thermal camera.
Each input pixel is mapped through a selectable palette: plain gray, inverted gray, "hot" (black-red-yellow-white) or "jet" (blue-cyan-yellow-red).
Sits between the thermal normalisation stage and the RGB565 framebuffer/HDMI writer.
Carries a valid/ready stream with frame/line sideband, a 3-stage pipeline and full backpressure.

Parameters:
P_RESET_MODE, 2'd2, palette selected after reset (0 gray, 1 hot, 2 jet, 3 inverted gray)

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, active-high
i_gray  input  8  input pixel intensity
i_valid  input  1  input pixel valid
i_sof  input  1  input pixel is first of frame (qualified by i_valid)
i_eol  input  1  input pixel is last of line (qualified by i_valid)
o_ready  output  1  block can accept input this cycle
i_mode  input  2  requested palette, applied at frame boundaries only
o_rgb  output  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
o_valid  output  1  output pixel valid
o_sof  output  1  sof aligned with o_rgb
o_eol  output  1  eol aligned with o_rgb
i_ready  input  1  downstream accepts output
o_mode  output  2  palette currently in effect

Behaviour:
- One clock (i_clk). Reset is asynchronous and active-high (i_rst). No other clock domains.
- Reset values:
  - o_valid, o_sof, o_eol = 0
  - o_rgb = 16'h0000
  - o_mode = P_RESET_MODE
  - all stage valids = 0
- Reset takes effect immediately, mid-stream included. Pixels in flight are discarded.
- Pipeline: S1 registers input, S2 computes R8/G8/B8, S3 packs RGB565 into the output registers.
- Global enable: en = i_ready | ~o_valid, with o_ready = en.
  - When en = 1, all stages advance.
  - When en = 0, every stage register holds, and o_rgb/o_sof/o_eol stay stable.
- Latency: 3 cycles from input handshake (i_valid & o_ready) to o_valid when unstalled. Throughput is 1 pixel/cycle.
- An input is accepted only on i_valid & o_ready. Input bubbles propagate as invalid stages. No pixel is dropped or duplicated; order is preserved.
- Mode latch:
  - o_mode <= i_mode on an accepted pixel with i_sof = 1. The mode is applied to that pixel and to all later pixels.
  - i_mode changes at any other time are ignored.
  - Each S1 entry captures the mode it will be mapped with, so a switch never alters pixels already in flight.
- Palettes, on g = i_gray, producing 8-bit R8/G8/B8:
  - mode 0 (gray): R8 = G8 = B8 = g
  - mode 3 (inverted gray): R8 = G8 = B8 = 255 - g
  - mode 1 (hot), with t = 3*g computed at 10 bits:
    - R8 = min(t, 255)
    - G8 = clamp(t - 255, 0, 255)
    - B8 = clamp(t - 510, 0, 255)
  - mode 2 (jet), with s = g[7:6] and f = {g[5:0], 2'b00}:
    - s = 0: R = 0, G = f, B = 255
    - s = 1: R = 0, G = 255, B = 255 - f
    - s = 2: R = f, G = 255, B = 0
    - s = 3: R = 255, G = 255 - f, B = 0
- Pack by truncation, no rounding: o_rgb = {R8[7:3], G8[7:2], B8[7:3]}.
- Sideband sof/eol travel with their pixel through every stage.
- Simultaneous i_sof and mode change on the same accepted pixel: the new mode applies to that pixel.

Test Plan:
- Mode 0, accept g = 8'h80 with i_ready = 1 held -> o_valid rises exactly 3 cycles later with o_rgb = 16'h8410; g = 8'hFF -> 16'hFFFF; g = 8'h00 -> 16'h0000.
- Mode 1 (set via i_mode = 1 on a sof pixel) -> g = 100 gives 16'hF960; g = 0 gives 16'h0000; g = 255 gives 16'hFFFF.
- Mode 2 (reset default) -> g = 0 gives 16'h001F; g = 200 gives 16'hFEE0; g = 128 gives 16'h07E0.
- Stream 8'h10, 8'h20, 8'h30, 8'h40 in mode 0 with i_ready low for 5 cycles mid-stream -> o_ready low while stalled and o_rgb stable; outputs 16'h1082, 16'h2104, 16'h3186, 16'h4208 in order, none lost or repeated; sof/eol stay aligned.
- i_mode changed 0 -> 3 mid-frame without sof -> o_mode stays 0 and pixels are unchanged. On the next sof pixel with g = 8'h00 -> o_mode = 3 and o_rgb = 16'hFFFF.
- Assert i_rst asynchronously with 3 pixels in flight -> o_valid = 0 and o_rgb = 0 within the same cycle; o_mode = 2. No stale pixel appears after release.
